// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl
// Round sequencer for the masked Keccak-f[1600] core. It accepts a start
// request, pulses the share load, walks the round index (25-NUM_ROUNDS .. 24)
// with STAGES datapath cycles per round, then holds a completion handshake.
//
// Optional feature macro: KECCAK_RND_STALL_EN
//   defined   -> rnd_valid_i / rnd_ready_o exist; the datapath only advances
//                in cycles where fresh mask randomness is offered.
//   undefined -> the datapath advances in every RUN cycle.
//
// Handshakes (valid/ready): a transfer happens in a cycle where both valid
// and ready are high at the rising clock edge. start_ready_o and done_valid_o
// are pure decodes of the registered state, so neither depends on the
// partner's signal in the same cycle. Under the macro, rnd_ready_o rises
// combinationally with rnd_valid_i during RUN to report consumption.
//
// state_o exposes the FSM state for debug / checker binding:
//   0 = IDLE, 1 = LOAD, 2 = RUN, 3 = DONE.

module keccak_round_ctrl #(
    parameter int NUM_ROUNDS = 24,
    parameter int STAGES     = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_valid_i,
    output logic       start_ready_o,
    input  logic       abort_i,
    output logic       load_o,
    output logic       round_en_o,
    output logic [4:0] round_number_o,
    output logic [2:0] stage_o,
    output logic       last_round_o,
    output logic       busy_o,
    output logic       done_valid_o,
    input  logic       done_ready_i,
`ifdef KECCAK_RND_STALL_EN
    input  logic       rnd_valid_i,
    output logic       rnd_ready_o,
`endif
    output logic [1:0] state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Keccak-p convention: a reduced-round permutation runs the final rounds.
    localparam logic [4:0] FIRST_ROUND = 5'(25 - NUM_ROUNDS);
    localparam logic [4:0] LAST_ROUND  = 5'd24;
    localparam logic [2:0] LAST_STAGE  = 3'(STAGES - 1);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [4:0] round_q;
    logic [4:0] round_d;
    logic [2:0] stage_q;
    logic [2:0] stage_d;

    logic in_run;
    logic rnd_ok;
    logic advance;
    logic stage_wrap;
    logic round_last;

    assign in_run = (state_q == ST_RUN);

`ifdef KECCAK_RND_STALL_EN
    // Without fresh masks the masked datapath must not step.
    assign rnd_ok = rnd_valid_i;
`else
    assign rnd_ok = 1'b1;
`endif

    assign advance    = in_run & rnd_ok;
    assign stage_wrap = (stage_q == LAST_STAGE);
    assign round_last = (round_q == LAST_ROUND);

    // Next-state and counter update; abort overrides every other event.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        stage_d = stage_q;
        if (abort_i) begin
            state_d = ST_IDLE;
            round_d = '0;
            stage_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    round_d = '0;
                    stage_d = '0;
                    if (start_valid_i) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_RUN;
                    round_d = FIRST_ROUND;
                    stage_d = '0;
                end
                ST_RUN: begin
                    if (advance) begin
                        if (stage_wrap) begin
                            stage_d = '0;
                            if (round_last) begin
                                // Final stage of round 24 completes the permutation.
                                state_d = ST_DONE;
                                round_d = '0;
                            end else begin
                                round_d = round_q + 5'd1;
                            end
                        end else begin
                            stage_d = stage_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    round_d = '0;
                    stage_d = '0;
                    if (done_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    round_d = '0;
                    stage_d = '0;
                end
            endcase
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            stage_q <= stage_d;
        end
    end

    // Output decode from registered state only (round_en_o also sees rnd_valid_i under the macro).
    always_comb begin
        start_ready_o  = (state_q == ST_IDLE);
        load_o         = (state_q == ST_LOAD);
        busy_o         = (state_q != ST_IDLE);
        done_valid_o   = (state_q == ST_DONE);
        round_en_o     = advance;
        round_number_o = in_run ? round_q : 5'd0;
        stage_o        = in_run ? stage_q : 3'd0;
        last_round_o   = in_run & round_last;
        state_o        = state_q;
    end

`ifdef KECCAK_RND_STALL_EN
    // Randomness is consumed exactly when the datapath steps.
    assign rnd_ready_o = advance;
`endif

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Testbench for keccak_round_ctrl: a default instance (24 rounds, 2 stages)
// and a reduced instance (12 rounds, 1 stage) share all inputs. A behavioural
// model counts completed datapath steps per permutation and derives round and
// stage from that count with plain division.

module tb_keccak_round_ctrl;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic start_valid;
    logic abort;
    logic done_ready;
`ifdef KECCAK_RND_STALL_EN
    logic rnd_valid;
    logic [1:0] rnd_ready_w;
`endif

    logic [1:0]       start_ready_w;
    logic [1:0]       load_w;
    logic [1:0]       round_en_w;
    logic [1:0][4:0]  round_w;
    logic [1:0][2:0]  stage_w;
    logic [1:0]       last_w;
    logic [1:0]       busy_w;
    logic [1:0]       done_valid_w;
    logic [1:0][1:0]  state_w;

    keccak_round_ctrl #(.NUM_ROUNDS(24), .STAGES(2)) dut0 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_valid_i  (start_valid),
        .start_ready_o  (start_ready_w[0]),
        .abort_i        (abort),
        .load_o         (load_w[0]),
        .round_en_o     (round_en_w[0]),
        .round_number_o (round_w[0]),
        .stage_o        (stage_w[0]),
        .last_round_o   (last_w[0]),
        .busy_o         (busy_w[0]),
        .done_valid_o   (done_valid_w[0]),
        .done_ready_i   (done_ready),
`ifdef KECCAK_RND_STALL_EN
        .rnd_valid_i    (rnd_valid),
        .rnd_ready_o    (rnd_ready_w[0]),
`endif
        .state_o        (state_w[0])
    );

    keccak_round_ctrl #(.NUM_ROUNDS(12), .STAGES(1)) dut1 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_valid_i  (start_valid),
        .start_ready_o  (start_ready_w[1]),
        .abort_i        (abort),
        .load_o         (load_w[1]),
        .round_en_o     (round_en_w[1]),
        .round_number_o (round_w[1]),
        .stage_o        (stage_w[1]),
        .last_round_o   (last_w[1]),
        .busy_o         (busy_w[1]),
        .done_valid_o   (done_valid_w[1]),
        .done_ready_i   (done_ready),
`ifdef KECCAK_RND_STALL_EN
        .rnd_valid_i    (rnd_valid),
        .rnd_ready_o    (rnd_ready_w[1]),
`endif
        .state_o        (state_w[1])
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks;
    int failures;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 load, 2 run, 3 done; k = datapath steps taken in this run.
    int m_phase[2];
    int m_k[2];

    function automatic int nr_of(input int i);
        return (i == 0) ? 24 : 12;
    endfunction

    function automatic int st_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic bit m_step_ok();
`ifdef KECCAK_RND_STALL_EN
        return rnd_valid;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] <= 0;
                m_k[i]     <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (abort) begin
                    m_phase[i] <= 0;
                    m_k[i]     <= 0;
                end else begin
                    case (m_phase[i])
                        0: if (start_valid) m_phase[i] <= 1;
                        1: begin
                            m_phase[i] <= 2;
                            m_k[i]     <= 0;
                        end
                        2: if (m_step_ok()) begin
                            if (m_k[i] == nr_of(i) * st_of(i) - 1) begin
                                m_phase[i] <= 3;
                                m_k[i]     <= 0;
                            end else begin
                                m_k[i] <= m_k[i] + 1;
                            end
                        end
                        3: if (done_ready) m_phase[i] <= 0;
                        default: m_phase[i] <= 0;
                    endcase
                end
            end
        end
    end

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            int  e_round;
            int  e_stage;
            bit  e_run;
            bit  e_en;
            e_run   = (m_phase[i] == 2);
            e_en    = e_run && m_step_ok();
            e_round = e_run ? (25 - nr_of(i) + m_k[i] / st_of(i)) : 0;
            e_stage = e_run ? (m_k[i] % st_of(i)) : 0;
            chk($sformatf("m%0d_start_ready", i), start_ready_w[i], (m_phase[i] == 0) ? 1 : 0);
            chk($sformatf("m%0d_load", i), load_w[i], (m_phase[i] == 1) ? 1 : 0);
            chk($sformatf("m%0d_round_en", i), round_en_w[i], e_en ? 1 : 0);
            chk($sformatf("m%0d_round", i), round_w[i], e_round);
            chk($sformatf("m%0d_stage", i), stage_w[i], e_stage);
            chk($sformatf("m%0d_last", i), last_w[i], (e_round == 24) ? 1 : 0);
            chk($sformatf("m%0d_busy", i), busy_w[i], (m_phase[i] != 0) ? 1 : 0);
            chk($sformatf("m%0d_done_valid", i), done_valid_w[i], (m_phase[i] == 3) ? 1 : 0);
            chk($sformatf("m%0d_state", i), state_w[i], m_phase[i]);
`ifdef KECCAK_RND_STALL_EN
            chk($sformatf("m%0d_rnd_ready", i), rnd_ready_w[i], e_en ? 1 : 0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s%0d_start_ready", tag, i), start_ready_w[i], 1);
            chk($sformatf("%s%0d_load", tag, i), load_w[i], 0);
            chk($sformatf("%s%0d_round_en", tag, i), round_en_w[i], 0);
            chk($sformatf("%s%0d_round", tag, i), round_w[i], 0);
            chk($sformatf("%s%0d_stage", tag, i), stage_w[i], 0);
            chk($sformatf("%s%0d_last", tag, i), last_w[i], 0);
            chk($sformatf("%s%0d_busy", tag, i), busy_w[i], 0);
            chk($sformatf("%s%0d_done_valid", tag, i), done_valid_w[i], 0);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    // kind 0: wait for dut0 round r / stage s; kind 1: wait for dut0 done_valid.
    // Returns at negedge+1 of the matching cycle, before its rising edge.
    task automatic wait_for(input string tag, input int kind, input int r, input int s);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (kind == 0) ok = (round_w[0] == r) && (stage_w[0] == s);
            else           ok = done_valid_w[0];
        end
        chk({tag, "_wait_timeout"}, ok, 1);
    endtask

    // Start in cycle 0 with done_ready=1; literal cycle expectations.
    task automatic timed_run(input string tag);
        for (int c = 0; c <= 51; c++) begin
            @(negedge clk);
            start_valid = (c == 0);
            done_ready  = 1'b1;
            abort       = 1'b0;
            #1;
            if (c == 0)  chk({tag, "_ready_c0"}, start_ready_w[0], 1);
            if (c == 1)  chk({tag, "_load_c1"}, load_w[0], 1);
            if (c == 2)  chk({tag, "_round_c2"}, round_w[0], 1);
            if (c == 2)  chk({tag, "_r12_round_c2"}, round_w[1], 13);
            if (c == 3)  chk({tag, "_stage_c3"}, stage_w[0], 1);
            if (c == 13) chk({tag, "_r12_round_c13"}, round_w[1], 24);
            if (c == 13) chk({tag, "_r12_last_c13"}, last_w[1], 1);
            if (c == 14) chk({tag, "_r12_done_c14"}, done_valid_w[1], 1);
            if (c == 48) chk({tag, "_round_c48"}, round_w[0], 24);
            if (c == 49) chk({tag, "_round_c49"}, round_w[0], 24);
            if (c == 49) chk({tag, "_last_c49"}, last_w[0], 1);
            if (c == 49) chk({tag, "_done_c49"}, done_valid_w[0], 0);
            if (c == 50) chk({tag, "_done_c50"}, done_valid_w[0], 1);
            if (c == 50) chk({tag, "_round_c50"}, round_w[0], 0);
            if (c == 51) chk({tag, "_idle_c51"}, start_ready_w[0], 1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        abort       = 1'b0;
        done_ready  = 1'b1;
`ifdef KECCAK_RND_STALL_EN
        rnd_valid   = 1'b1;
`endif
        #3;
        check_reset_values("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Nominal timing for both configurations.
        timed_run("run1");

        // DONE held with done_ready low; start offered meanwhile is ignored.
        done_ready = 1'b0;
        start_pulse();
        wait_for("hold", 1, 0, 0);
        start_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("hold_done_k%0d", k), done_valid_w[0], 1);
            chk($sformatf("hold_ready_k%0d", k), start_ready_w[0], 0);
            chk($sformatf("hold_load_k%0d", k), load_w[0], 0);
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(negedge clk);
        #1;
        chk("hold_release_idle", start_ready_w[0], 1);
        chk("hold_release_done", done_valid_w[0], 0);

        // Abort at round 7 stage 1, coinciding with an advance and a start.
        start_pulse();
        wait_for("abort", 0, 7, 1);
        abort       = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        abort       = 1'b0;
        start_valid = 1'b0;
        #1;
        chk("abort_round", round_w[0], 0);
        chk("abort_ready", start_ready_w[0], 1);
        chk("abort_done", done_valid_w[0], 0);
        chk("abort_busy", busy_w[0], 0);
        chk("abort_r12_noload", load_w[1], 0);

        // Asynchronous reset mid-run, then a clean permutation.
        start_pulse();
        wait_for("reset", 0, 10, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        timed_run("run2");

`ifdef KECCAK_RND_STALL_EN
        // Randomness withheld for three cycles in round 5 stalls by three cycles.
        for (int c = 0; c <= 53; c++) begin
            @(negedge clk);
            start_valid = (c == 0);
            done_ready  = 1'b1;
            rnd_valid   = !(c >= 10 && c <= 12);
            #1;
            if (c == 11) chk("stall_rnd_ready_c11", rnd_ready_w[0], 0);
            if (c == 12) chk("stall_round_c12", round_w[0], 5);
            if (c == 13) chk("stall_stage_c13", stage_w[0], 0);
            if (c == 14) chk("stall_stage_c14", stage_w[0], 1);
            if (c == 52) chk("stall_done_c52", done_valid_w[0], 0);
            if (c == 53) chk("stall_done_c53", done_valid_w[0], 1);
        end
`endif

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            start_valid = ($urandom_range(0, 3) == 0);
            done_ready  = ($urandom_range(0, 1) == 1);
            abort       = ($urandom_range(0, 63) == 0);
`ifdef KECCAK_RND_STALL_EN
            rnd_valid   = ($urandom_range(0, 3) != 0);
`endif
        end
        @(negedge clk);
        start_valid = 1'b0;
        abort       = 1'b0;
        @(negedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
